// File: rtl/mult_sched_pkg.sv
// Shared types for the two-port multiplier scheduler: FSM states and requester index.
package mult_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic req_idx_t;

  localparam req_idx_t REQ0 = 1'b0;
  localparam req_idx_t REQ1 = 1'b1;

endpackage

// File: rtl/shift_add_mult_core.sv
// Sequential shift-add multiplier: latches operands on start, then adds one
// shifted partial product per cycle for exactly WIDTH cycles.
// done is high during the final step, so the caller can change state on the
// same edge that completes the product.
module shift_add_mult_core #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   acc,
  output logic                 done
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [CW-1:0]      cnt_reg;
  logic               active_reg;

  // One partial product per multiplier bit; the counter selects which one is added.
  logic [2*WIDTH-1:0] pp [WIDTH];

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pp
      assign pp[gi] = b_reg[gi] ? ({{WIDTH{1'b0}}, a_reg} << gi) : '0;
    end
  endgenerate

  assign done = active_reg && (cnt_reg == CW'(WIDTH - 1));
  assign acc  = acc_reg;

  // Operand capture on start, then one accumulate step per cycle while active.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      active_reg <= 1'b0;
    end else if (start) begin
      a_reg      <= a;
      b_reg      <= b;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      active_reg <= 1'b1;
    end else if (active_reg) begin
      acc_reg <= acc_reg + pp[cnt_reg];
      cnt_reg <= cnt_reg + 1'b1;
      if (done) begin
        active_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/shared_mult_scheduler.sv
// Two-requester front end for a single shift-add multiplier: round-robin
// arbitration in IDLE, WIDTH-cycle compute in BUSY, result held in DONE
// until the owning requester takes it.
module shared_mult_scheduler
  import mult_sched_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid0,
  output logic                 req_ready0,
  input  logic [WIDTH-1:0]     req_a0,
  input  logic [WIDTH-1:0]     req_b0,
  input  logic                 req_valid1,
  output logic                 req_ready1,
  input  logic [WIDTH-1:0]     req_a1,
  input  logic [WIDTH-1:0]     req_b1,
  output logic                 resp_valid0,
  input  logic                 resp_ready0,
  output logic [2*WIDTH-1:0]   resp_data0,
  output logic                 resp_valid1,
  input  logic                 resp_ready1,
  output logic [2*WIDTH-1:0]   resp_data1
);

  state_t   state_reg;
  req_idx_t owner_reg;
  req_idx_t last_grant_reg;
  logic     resp_valid0_reg;
  logic     resp_valid1_reg;

  logic               idle;
  logic               fire0;
  logic               fire1;
  logic               start;
  logic               owner_take;
  logic [WIDTH-1:0]   start_a;
  logic [WIDTH-1:0]   start_b;
  logic [2*WIDTH-1:0] core_acc;
  logic               core_done;

  // Readiness looks only at the other requester's valid, so the two grants
  // are mutually exclusive whenever both are valid.
  assign idle       = (state_reg == IDLE);
  assign req_ready0 = idle && (!req_valid1 || (last_grant_reg == REQ1));
  assign req_ready1 = idle && (!req_valid0 || (last_grant_reg == REQ0));
  assign fire0      = req_valid0 && req_ready0;
  assign fire1      = req_valid1 && req_ready1;
  assign start      = fire0 || fire1;
  assign start_a    = fire1 ? req_a1 : req_a0;
  assign start_b    = fire1 ? req_b1 : req_b0;

  // Only the owner's resp_ready can release the held result.
  assign owner_take = (owner_reg == REQ1) ? resp_ready1 : resp_ready0;

  assign resp_valid0 = resp_valid0_reg;
  assign resp_valid1 = resp_valid1_reg;
  assign resp_data0  = resp_valid0_reg ? core_acc : '0;
  assign resp_data1  = resp_valid1_reg ? core_acc : '0;

  shift_add_mult_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (start_a),
    .b     (start_b),
    .acc   (core_acc),
    .done  (core_done)
  );

  // Arbitration/compute/response FSM with registered response-valid flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      owner_reg       <= REQ0;
      last_grant_reg  <= REQ1;
      resp_valid0_reg <= 1'b0;
      resp_valid1_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            owner_reg      <= fire1 ? REQ1 : REQ0;
            last_grant_reg <= fire1 ? REQ1 : REQ0;
            state_reg      <= BUSY;
          end
        end
        BUSY: begin
          if (core_done) begin
            state_reg       <= DONE;
            resp_valid0_reg <= (owner_reg == REQ0);
            resp_valid1_reg <= (owner_reg == REQ1);
          end
        end
        DONE: begin
          if (owner_take) begin
            state_reg       <= IDLE;
            resp_valid0_reg <= 1'b0;
            resp_valid1_reg <= 1'b0;
          end
        end
        default: begin
          state_reg       <= IDLE;
          resp_valid0_reg <= 1'b0;
          resp_valid1_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shared_mult_scheduler.sv
// Directed plus randomized bench for shared_mult_scheduler (WIDTH=4), checked
// every cycle against a transaction-level model: a*b products, a countdown of
// WIDTH compute cycles, and the round-robin grant rule.
module tb_shared_mult_scheduler;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           req_valid0, req_valid1;
  logic           req_ready0, req_ready1;
  logic [W-1:0]   req_a0, req_b0, req_a1, req_b1;
  logic           resp_valid0, resp_valid1;
  logic           resp_ready0, resp_ready1;
  logic [2*W-1:0] resp_data0, resp_data1;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_busy_left;   // compute cycles still to run
  bit m_has_result;  // a product is waiting for its owner
  bit m_owner;
  bit m_last;
  int m_prod;
  int cyc = 0;
  int acc1_q[$];     // cycles at which requester 1 was accepted

  always #5 clk = ~clk;

  shared_mult_scheduler #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid0  (req_valid0),
    .req_ready0  (req_ready0),
    .req_a0      (req_a0),
    .req_b0      (req_b0),
    .req_valid1  (req_valid1),
    .req_ready1  (req_ready1),
    .req_a1      (req_a1),
    .req_b1      (req_b1),
    .resp_valid0 (resp_valid0),
    .resp_ready0 (resp_ready0),
    .resp_data0  (resp_data0),
    .resp_valid1 (resp_valid1),
    .resp_ready1 (resp_ready1),
    .resp_data1  (resp_data1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy_left  = 0;
    m_has_result = 0;
    m_owner      = 0;
    m_last       = 1;
    m_prod       = 0;
  endtask

  // Check all outputs mid-cycle, then advance the model across the rising edge.
  task automatic tick();
    bit idle, er0, er1, ev0, ev1;
    #1;
    idle = (m_busy_left == 0) && !m_has_result;
    er0  = idle && (!req_valid0 || 1'b1) && (!req_valid1 || m_last);
    er1  = idle && (!req_valid0 || !m_last);
    ev0  = m_has_result && !m_owner;
    ev1  = m_has_result && m_owner;
    chk("req_ready0",  {31'd0, req_ready0},  {31'd0, er0});
    chk("req_ready1",  {31'd0, req_ready1},  {31'd0, er1});
    chk("resp_valid0", {31'd0, resp_valid0}, {31'd0, ev0});
    chk("resp_valid1", {31'd0, resp_valid1}, {31'd0, ev1});
    chk("resp_data0",  {24'd0, resp_data0},  ev0 ? m_prod : 0);
    chk("resp_data1",  {24'd0, resp_data1},  ev1 ? m_prod : 0);
    @(posedge clk);
    cyc++;
    if (rst) begin
      model_reset();
    end else if (idle) begin
      if (req_valid0 && er0) begin
        m_owner = 0; m_last = 0;
        m_prod = int'(req_a0) * int'(req_b0);
        m_busy_left = W;
      end else if (req_valid1 && er1) begin
        m_owner = 1; m_last = 1;
        m_prod = int'(req_a1) * int'(req_b1);
        m_busy_left = W;
        acc1_q.push_back(cyc);
      end
    end else if (m_busy_left > 0) begin
      m_busy_left--;
      if (m_busy_left == 0) m_has_result = 1;
    end else if (m_owner ? resp_ready1 : resp_ready0) begin
      m_has_result = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    req_valid0 = 0; req_valid1 = 0;
    req_a0 = 0; req_b0 = 0; req_a1 = 0; req_b1 = 0;
    resp_ready0 = 0; resp_ready1 = 0;
    repeat (3) @(negedge clk);
    model_reset();
    tick();                         // reset still asserted: outputs idle
    rst = 1'b0;

    // 1: reset in the middle of a 3*2 operation
    tick();
    req_valid0 = 1; req_a0 = 3; req_b0 = 2;
    tick();
    req_valid0 = 0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    resp_ready0 = 1; resp_ready1 = 1;
    repeat (6) tick();

    // 2: 3*2, result held three cycles, operands changed after accept
    resp_ready0 = 0;
    req_valid0 = 1; req_a0 = 3; req_b0 = 2;
    tick();
    req_valid0 = 0; req_a0 = 7; req_b0 = 7;
    repeat (7) tick();
    resp_ready0 = 1;
    tick(); tick();

    // 3: both requesters valid continuously
    req_valid0 = 1; req_a0 = 2; req_b0 = 3;
    req_valid1 = 1; req_a1 = 5; req_b1 = 5;
    resp_ready0 = 1; resp_ready1 = 1;
    repeat (30) tick();
    req_valid0 = 0; req_valid1 = 0;
    repeat (6) tick();

    // 4: maximum operands and a zero multiplicand
    req_valid1 = 1; req_a1 = 15; req_b1 = 15;
    tick();
    req_valid1 = 0;
    repeat (6) tick();
    req_valid0 = 1; req_a0 = 0; req_b0 = 9;
    tick();
    req_valid0 = 0;
    repeat (6) tick();

    // 5: lone requester 1, three back-to-back operations
    acc1_q.delete();
    req_valid1 = 1; req_a1 = 6; req_b1 = 9;
    repeat (18) tick();
    req_valid1 = 0;
    chk("acc1_count", acc1_q.size(), 3);
    if (acc1_q.size() == 3) begin
      chk("acc1_gap_a", acc1_q[1] - acc1_q[0], W + 2);
      chk("acc1_gap_b", acc1_q[2] - acc1_q[1], W + 2);
    end
    repeat (4) tick();

    // 6: owner 0 in DONE, only the non-owner ready
    resp_ready0 = 0; resp_ready1 = 1;
    req_valid0 = 1; req_a0 = 5; req_b0 = 3;
    tick();
    req_valid0 = 0;
    repeat (10) tick();
    resp_ready0 = 1;
    tick(); tick();

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      req_valid0  = ($urandom_range(0, 3) != 0);
      req_valid1  = ($urandom_range(0, 3) != 0);
      req_a0      = W'($urandom);
      req_b0      = W'($urandom);
      req_a1      = W'($urandom);
      req_b1      = W'($urandom);
      resp_ready0 = ($urandom_range(0, 2) != 0);
      resp_ready1 = ($urandom_range(0, 2) != 0);
      rst         = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
